// File: rtl/wave_serializer.sv
// wave_serializer: captures one parallel sample per valid/ready handshake and shifts it out one bit per clock, with optional even parity and an idle gap between words
module wave_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int N = WIDTH + (PARITY_EN ? 1 : 0);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [7:0] GLAST = 8'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [N-1:0] sr_q, sr_d, frame;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] gcnt_q, gcnt_d;
  logic out_q, out_d, val_q, val_d, fs_q, fs_d, busy_q, busy_d;
  logic [WIDTH-1:0] ord;
  logic last, accept;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) ord[i] = MSB_FIRST ? in_data[i] : in_data[WIDTH-1-i];
    frame = '0;
    frame[N-1 -: WIDTH] = ord;
    if (PARITY_EN) frame[0] = ^in_data;
  end
  assign last = (state_q == S_SHIFT) && (cnt_q == LAST);
  assign in_ready = (state_q == S_IDLE) || (last && GAP == 0);
  assign accept = in_valid && in_ready;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    gcnt_d = gcnt_q;
    out_d = 1'b0;
    val_d = 1'b0;
    fs_d = 1'b0;
    if (accept) begin
      state_d = S_SHIFT;
      sr_d = frame << 1;
      cnt_d = '0;
      out_d = frame[N-1];
      val_d = 1'b1;
      fs_d = 1'b1;
    end else if (state_q == S_SHIFT && !last) begin
      sr_d = sr_q << 1;
      cnt_d = cnt_q + 1'b1;
      out_d = sr_q[N-1];
      val_d = 1'b1;
    end else if (last) begin
      state_d = (GAP > 0) ? S_GAP : S_IDLE;
      gcnt_d = '0;
    end else if (state_q == S_GAP) begin
      state_d = (gcnt_q == GLAST) ? S_IDLE : S_GAP;
      gcnt_d = (gcnt_q == GLAST) ? gcnt_q : gcnt_q + 8'd1;
    end
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      gcnt_q <= '0;
      out_q <= 1'b0;
      val_q <= 1'b0;
      fs_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      gcnt_q <= gcnt_d;
      out_q <= out_d;
      val_q <= val_d;
      fs_q <= fs_d;
      busy_q <= busy_d;
    end
  end
  assign ser_out = out_q;
  assign ser_valid = val_q;
  assign frame_start = fs_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_wave_serializer.sv
// tb_wave_serializer: directed checks of four serializer configurations sharing one stimulus
module tb_wave_serializer;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] rdy, so, sv, fs, bz;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  wave_serializer u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .busy(bz[0]));
  wave_serializer #(.MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .busy(bz[1]));
  wave_serializer #(.PARITY_EN(1'b1)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .busy(bz[2]));
  wave_serializer #(.GAP(2)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[3]), .ser_out(so[3]), .ser_valid(sv[3]), .frame_start(fs[3]), .busy(bz[3]));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic idle_chk(input int u, input string tag);
    chk({tag, " ser_valid"}, 32'(sv[u]), 0);
    chk({tag, " ser_out"}, 32'(so[u]), 0);
    chk({tag, " busy"}, 32'(bz[u]), 0);
    chk({tag, " in_ready"}, 32'(rdy[u]), 1);
  endtask
  task automatic send(input logic [7:0] d, input bit hold);
    in_data = d;
    in_valid = 1'b1;
    step();
    in_valid = hold;
  endtask
  task automatic check_word(input int u, input logic [31:0] bits, input int n, input logic [31:0] fm, input int drop);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("u%0d ser_valid b%0d", u, i), 32'(sv[u]), 1);
      chk($sformatf("u%0d ser_out b%0d", u, i), 32'(so[u]), 32'(bits[n-1-i]));
      chk($sformatf("u%0d frame_start b%0d", u, i), 32'(fs[u]), 32'(fm[n-1-i]));
      chk($sformatf("u%0d busy b%0d", u, i), 32'(bz[u]), 1);
      step();
      if (i == drop) in_valid = 1'b0;
    end
  endtask
  initial begin
    do_reset();
    idle_chk(0, "reset");
    chk("reset frame_start", 32'(fs[0]), 0);
    send(8'hA5, 1'b0);
    check_word(0, 32'h0A5, 8, 32'h80, -1);
    idle_chk(0, "t1 after");
    do_reset();
    send(8'h01, 1'b0);
    check_word(1, 32'h080, 8, 32'h80, -1);
    idle_chk(1, "t2 after");
    do_reset();
    send(8'hA5, 1'b0);
    check_word(2, 32'h14A, 9, 32'h100, -1);
    idle_chk(2, "t3a after");
    send(8'h07, 1'b0);
    check_word(2, 32'h00F, 9, 32'h100, -1);
    idle_chk(2, "t3b after");
    do_reset();
    send(8'hF0, 1'b1);
    in_data = 8'h0F;
    check_word(0, 32'hF00F, 16, 32'h8080, 7);
    idle_chk(0, "t4 after");
    do_reset();
    send(8'h81, 1'b1);
    in_data = 8'h42;
    check_word(3, 32'h81, 8, 32'h80, -1);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("t5 gap%0d ser_valid", g), 32'(sv[3]), 0);
      chk($sformatf("t5 gap%0d busy", g), 32'(bz[3]), 1);
      chk($sformatf("t5 gap%0d in_ready", g), 32'(rdy[3]), 0);
      step();
    end
    idle_chk(3, "t5 idle");
    step();
    in_valid = 1'b0;
    check_word(3, 32'h42, 8, 32'h80, -1);
    do_reset();
    send(8'hFF, 1'b0);
    check_word(0, 32'h7, 3, 32'h4, -1);
    chk("t6 bit4 ser_out", 32'(so[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_chk(0, "t6 after rst");
    send(8'h3C, 1'b0);
    check_word(0, 32'h3C, 8, 32'h80, -1);
    idle_chk(0, "t6 after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
